// File: rtl/timer_scheduler.sv
// Shared time-base scheduler: arbitrates timeout requests and runs one N-unit timer at a time.
// Define TIMER_SCHED_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module timer_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned OWNER_W     = 2,
  parameter int unsigned DUR_W       = 8,
  parameter int unsigned UNIT_CYCLES = 50000,
  parameter int unsigned PRESC_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [OWNER_W-1:0]       owner,
  output logic                     tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(UNIT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;

  logic               found_c;
  logic [OWNER_W-1:0] win_c;
  logic [DUR_W-1:0]   dur_sel_c;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

`ifndef TIMER_SCHED_STRICT_PRIO_EN
  logic [OWNER_W-1:0] ptr_q;
  logic               adv_c;

  // Pointer moves past the last grantee once its timer completes or is aborted.
  assign adv_c = (state_q == S_DONE) ||
                 (abort && ((state_q == S_GRANT) || (state_q == S_RUN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (adv_c) begin
      ptr_q <= (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
    end
  end
`endif

  // Winner search: indices at or above the pointer first, then wrap to the bottom.
  always_comb begin
    found_c   = 1'b0;
    win_c     = '0;
    dur_sel_c = '0;
`ifndef TIMER_SCHED_STRICT_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_c && req[i] && (OWNER_W'(i) >= ptr_q)) begin
        found_c = 1'b1;
        win_c   = OWNER_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_c && req[i]) begin
        found_c = 1'b1;
        win_c   = OWNER_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OWNER_W'(i) == win_c) dur_sel_c = dur[i*DUR_W +: DUR_W];
    end
  end

  // The grant cycle counts as the first prescaler cycle of the first unit.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    ack_d   = '0;
    done_d  = '0;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (found_c) begin
          state_d = S_GRANT;
          owner_d = win_c;
          rem_d   = dur_sel_c;
          ack_d   = onehot(win_c);
        end
      end
      S_GRANT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = onehot(owner_q);
        end else begin
          state_d = S_RUN;
          presc_d = PRESC_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = onehot(owner_q);
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          rem_d   = rem_q - DUR_W'(1);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a 4-cycle time unit and four requesters.
module tb_timer_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OWNER_W = 2;
  localparam int unsigned DUR_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DUR_W-1:0] dur;
  logic                     abort;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [OWNER_W-1:0]       owner;
  logic                     tick;

  int checks = 0;
  int passes = 0;

  timer_scheduler #(
    .NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W), .DUR_W(DUR_W),
    .UNIT_CYCLES(4), .PRESC_W(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .dur(dur), .abort(abort),
    .ack(ack), .done(done), .busy(busy), .owner(owner), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until an ack appears or the budget runs out; n is the cycles taken.
  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while ((ack == '0) && (n < budget));
  endtask

  initial begin
    int n;
    int ticks;
    int seen_done;
    logic [NUM_REQ-1:0] exp_ack;

    reset = 1'b1; req = '0; dur = '0; abort = 1'b0;
    step(3);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_tick", 32'(tick), 0);
    reset = 1'b0;
    step(2);

    // Single request, three units
    req = 4'b0001; dur[0*DUR_W +: DUR_W] = 8'd3;
    step(1);
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_busy", 32'(busy), 1);
    req = '0;
    step(3);
    chk("single_notick", 32'(tick), 0);
    step(1);
    chk("single_tick1", 32'(tick), 1);
    step(4);
    chk("single_tick2", 32'(tick), 1);
    step(4);
    chk("single_tick3", 32'(tick), 1);
    chk("single_early_done", 32'(done), 0);
    step(1);
    chk("single_done", 32'(done), 32'h1);
    chk("single_busy_done", 32'(busy), 1);
    step(1);
    chk("single_idle", 32'(busy), 0);
    chk("single_done_clr", 32'(done), 0);

    // Zero duration on requester 2
    req = 4'b0100; dur[2*DUR_W +: DUR_W] = 8'd0;
    step(1);
    chk("zero_ack", 32'(ack), 32'h4);
    chk("zero_owner", 32'(owner), 2);
    req = '0;
    step(1);
    chk("zero_done", 32'(done), 32'h4);
    step(1);
    chk("zero_idle", 32'(busy), 0);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dur = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef TIMER_SCHED_STRICT_PRIO_EN
      exp_ack = 4'b0001;
`else
      exp_ack = 4'b0001 << (g % 4);
`endif
      wait_ack(10, n);
      chk("rr_ack", 32'(ack), 32'(exp_ack));
      chk("rr_gap", 32'(n), (g == 0) ? 1 : 2);
      step(5);
      chk("rr_done", 32'(done), 32'(exp_ack));
    end
    req = '0;
    step(2);
    chk("rr_idle", 32'(busy), 0);

    // Abort mid-run on requester 1
    req = 4'b0010; dur[1*DUR_W +: DUR_W] = 8'd5;
    wait_ack(10, n);
    chk("abort_ack", 32'(ack), 32'h2);
    req = '0;
    step(9);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done != '0) seen_done++;
      step(1);
    end
    chk("abort_no_done", 32'(seen_done), 0);

    // Pointer advanced past 1; then abort on the final-unit expiry cycle
    dur[2*DUR_W +: DUR_W] = 8'd1;
    req = 4'b0111;
    wait_ack(10, n);
    chk("abort_next_ack", 32'(ack), 32'h4);
    req = '0;
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("final_abort_idle", 32'(busy), 0);
    chk("final_abort_tick", 32'(tick), 0);
    step(1);
    chk("final_abort_no_done", 32'(done), 0);
    dur[3*DUR_W +: DUR_W] = 8'd0;
    req = 4'b1111;
    wait_ack(10, n);
    chk("final_abort_ptr", 32'(ack), 32'h8);
    req = '0;
    step(1);
    chk("final_abort_next_done", 32'(done), 32'h8);
    step(2);

    // Reset during run, then a full rerun
    req = 4'b0001; dur[0*DUR_W +: DUR_W] = 8'd10;
    wait_ack(10, n);
    chk("rstrun_ack", 32'(ack), 32'h1);
    req = '0;
    step(12);
    chk("rstrun_tick3", 32'(tick), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rstrun_busy", 32'(busy), 0);
    chk("rstrun_tick", 32'(tick), 0);
    chk("rstrun_done", 32'(done), 0);
    chk("rstrun_ack0", 32'(ack), 0);
    req = 4'b0001;
    wait_ack(10, n);
    chk("rerun_ack", 32'(ack), 32'h1);
    chk("rerun_latency", 32'(n), 1);
    req = '0;
    ticks = 0;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (tick) ticks++;
      if (done != '0) seen_done++;
    end
    chk("rerun_ticks", 32'(ticks), 10);
    chk("rerun_no_early_done", 32'(seen_done), 0);
    step(1);
    chk("rerun_done", 32'(done), 32'h1);
    step(1);
    chk("rerun_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
